// File: rtl/input_script_player_pkg.sv
// Shared types and default sizing for the scripted Game & Watch button player.
package gw_input_pkg;

  localparam int unsigned DEF_NUM_BUTTONS = 8;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_SEL_W       = 8;
  localparam int unsigned DEF_DELTA_W     = 24;

  typedef enum logic [1:0] {
    OP_PRESS   = 2'd0,
    OP_RELEASE = 2'd1,
    OP_FINISH  = 2'd2
  } op_e;

  // Encoding 3 is reserved and behaves like OP_FINISH.
  typedef struct packed {
    logic [DEF_DELTA_W-1:0]     delta;
    op_e                        op;
    logic [DEF_NUM_BUTTONS-1:0] mask;
  } event_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_APPLY,
    S_DONE
  } state_e;

  function automatic logic is_edit(op_e op);
    return (op == OP_PRESS) || (op == OP_RELEASE);
  endfunction

endpackage

// File: rtl/input_script_player_if.sv
// Control, table/map write and status bundle of the input script player.
interface input_script_player_if
  import gw_input_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = DEF_NUM_BUTTONS,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned SEL_W       = DEF_SEL_W,
  parameter int unsigned DELTA_W     = DEF_DELTA_W
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BTN_W  = $clog2(NUM_BUTTONS);
  localparam int unsigned SELI_W = $clog2(SEL_W);

  logic                   step_tick_i;
  logic                   start_i;
  logic                   abort_i;
  logic                   wr_en_i;
  logic [ADDR_W-1:0]      wr_addr_i;
  logic [DELTA_W-1:0]     wr_delta_i;
  logic [1:0]             wr_op_i;
  logic [NUM_BUTTONS-1:0] wr_mask_i;
  logic                   map_wr_en_i;
  logic [BTN_W-1:0]       map_btn_i;
  logic [SELI_W-1:0]      map_sel_i;
  logic [1:0]             map_kbit_i;
  logic [SEL_W-1:0]       select_i;
  logic [3:0]             input_k_o;
  logic [NUM_BUTTONS-1:0] buttons_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   event_strobe_o;

  modport slave (
    input  step_tick_i, start_i, abort_i, wr_en_i, wr_addr_i, wr_delta_i, wr_op_i,
           wr_mask_i, map_wr_en_i, map_btn_i, map_sel_i, map_kbit_i, select_i,
    output input_k_o, buttons_o, busy_o, done_o, event_strobe_o
  );

  modport master (
    output step_tick_i, start_i, abort_i, wr_en_i, wr_addr_i, wr_delta_i, wr_op_i,
           wr_mask_i, map_wr_en_i, map_btn_i, map_sel_i, map_kbit_i, select_i,
    input  input_k_o, buttons_o, busy_o, done_o, event_strobe_o
  );

endinterface

// File: rtl/input_script_player_k_matrix.sv
// Maps held buttons onto the CPU K inputs through the select lines; purely combinational.
module input_k_matrix
  import gw_input_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = DEF_NUM_BUTTONS,
  parameter int unsigned SEL_W       = DEF_SEL_W
) (
  input  logic [NUM_BUTTONS-1:0]                    buttons_i,
  input  logic [NUM_BUTTONS-1:0][$clog2(SEL_W)-1:0] map_sel_i,
  input  logic [NUM_BUTTONS-1:0][1:0]               map_kbit_i,
  input  logic [SEL_W-1:0]                          select_i,
  output logic [3:0]                                input_k_o
);

  always_comb begin
    input_k_o = '0;
    for (int unsigned b = 0; b < NUM_BUTTONS; b++) begin
      if (buttons_i[b] && select_i[map_sel_i[b]]) input_k_o[map_kbit_i[b]] = 1'b1;
    end
  end

endmodule

// File: rtl/input_script_player.sv
// Replays a table of timed press/release/finish events, counted in retired CPU steps.
module input_script_player
  import gw_input_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = DEF_NUM_BUTTONS,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned SEL_W       = DEF_SEL_W,
  parameter int unsigned DELTA_W     = DEF_DELTA_W
) (
  input logic                  clk,
  input logic                  reset_n,
  input_script_player_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned SELI_W = $clog2(SEL_W);

  state_e                 state_q, state_d;
  event_t                 table_q [DEPTH];
  event_t                 work_q, work_d, entry_c;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [DELTA_W-1:0]     cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   strobe_q, strobe_d;
  logic                   last_c;

  logic [NUM_BUTTONS-1:0][SELI_W-1:0] map_sel_q;
  logic [NUM_BUTTONS-1:0][1:0]        map_kbit_q;

  assign entry_c = table_q[ptr_q];
  assign last_c  = (ptr_q == ADDR_W'(DEPTH - 1));

  // Event table has no reset so a script survives reset_n.
  always_ff @(posedge clk) begin
    if (bus.wr_en_i) begin
      table_q[bus.wr_addr_i] <= '{delta: bus.wr_delta_i, op: op_e'(bus.wr_op_i),
                                  mask: bus.wr_mask_i};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      map_sel_q  <= '0;
      map_kbit_q <= '0;
    end else if (bus.map_wr_en_i) begin
      map_sel_q[bus.map_btn_i]  <= bus.map_sel_i;
      map_kbit_q[bus.map_btn_i] <= bus.map_kbit_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state: abort outranks start, start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (bus.abort_i) begin
      state_d = S_IDLE;
    end else if (bus.start_i) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  state_d = (entry_c.delta == '0) ? S_APPLY : S_WAIT;
        S_WAIT:  if (bus.step_tick_i && (cnt_q == DELTA_W'(1))) state_d = S_APPLY;
        S_APPLY: state_d = (!is_edit(work_q.op) || last_c) ? S_DONE : S_LOAD;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath and registered status derived from the transition being taken.
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    buttons_d = buttons_q;
    done_d    = done_q;
    strobe_d  = 1'b0;
    if (bus.abort_i) begin
      buttons_d = '0;
    end else if (bus.start_i) begin
      ptr_d     = '0;
      buttons_d = '0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          work_d = entry_c;
          cnt_d  = entry_c.delta;
        end
        S_WAIT: if (bus.step_tick_i) cnt_d = cnt_q - DELTA_W'(1);
        S_APPLY: begin
          if (is_edit(work_q.op)) begin
            buttons_d = (work_q.op == OP_PRESS) ? (buttons_q | work_q.mask)
                                                : (buttons_q & ~work_q.mask);
            strobe_d  = 1'b1;
            ptr_d     = ptr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
    if (state_d == S_DONE) done_d = 1'b1;
    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_APPLY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      work_q    <= '0;
      buttons_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      buttons_q <= buttons_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      strobe_q  <= strobe_d;
    end
  end

  assign bus.buttons_o      = buttons_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.event_strobe_o = strobe_q;

  input_k_matrix #(
    .NUM_BUTTONS(NUM_BUTTONS),
    .SEL_W      (SEL_W)
  ) u_k_matrix (
    .buttons_i (buttons_q),
    .map_sel_i (map_sel_q),
    .map_kbit_i(map_kbit_q),
    .select_i  (bus.select_i),
    .input_k_o (bus.input_k_o)
  );

endmodule

// File: tb/tb_input_script_player.sv
// Directed and randomized playback checks against an event-level model of the script player.
`timescale 1ns/1ps
module tb_input_script_player;
  import gw_input_pkg::*;

  localparam int NB = DEF_NUM_BUTTONS;
  localparam int DP = DEF_DEPTH;
  localparam int SW = DEF_SEL_W;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  input_script_player_if bus ();
  input_script_player dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  always @(negedge clk) if (bus.event_strobe_o === 1'b1) strobes++;

  // Event-level model: table, map, and the expected player state.
  logic [23:0] m_delta [DP];
  logic [1:0]  m_op    [DP];
  logic [7:0]  m_mask  [DP];
  int          m_sel   [NB];
  int          m_kbit  [NB];
  logic [7:0]  m_btn;
  int          m_ptr;
  bit          m_busy, m_done;
  int          m_strobes;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic logic [3:0] model_k(logic [7:0] btn, logic [7:0] sel);
    logic [3:0] k = '0;
    for (int j = 0; j < 4; j++)
      for (int s = 0; s < SW; s++)
        for (int b = 0; b < NB; b++)
          if (sel[s] && btn[b] && m_sel[b] == s && m_kbit[b] == j) k[j] = 1'b1;
    return k;
  endfunction

  task automatic check_state(string tag);
    check({tag, "_buttons"}, 32'(bus.buttons_o), 32'(m_btn));
    check({tag, "_busy"},    32'(bus.busy_o),    32'(m_busy));
    check({tag, "_done"},    32'(bus.done_o),    32'(m_done));
    check({tag, "_strobes"}, 32'(strobes),       32'(m_strobes));
  endtask

  task automatic wr_ev(int a, int d, int op, int mask);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 4'(a); bus.wr_delta_i = 24'(d);
    bus.wr_op_i = 2'(op); bus.wr_mask_i = 8'(mask);
    m_delta[a] = 24'(d); m_op[a] = 2'(op); m_mask[a] = 8'(mask);
    step(1);
    bus.wr_en_i = 1'b0;
  endtask

  task automatic wr_map(int b, int s, int k);
    bus.map_wr_en_i = 1'b1; bus.map_btn_i = 3'(b); bus.map_sel_i = 3'(s); bus.map_kbit_i = 2'(k);
    m_sel[b] = s; m_kbit[b] = k;
    step(1);
    bus.map_wr_en_i = 1'b0;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1; step(1); bus.start_i = 1'b0; step(1);
    m_ptr = 0; m_btn = '0; m_done = 0; m_busy = 1;
  endtask

  task automatic do_abort();
    bus.abort_i = 1'b1; step(1); bus.abort_i = 1'b0;
    m_btn = '0; m_busy = 0;
  endtask

  task automatic tick();
    bus.step_tick_i = 1'b1; step(1); bus.step_tick_i = 1'b0; step(2);
  endtask

  // Plays the event at m_ptr: waits its delay, then checks the outcome.
  task automatic run_event(string tag);
    int unsigned d;
    d = m_delta[m_ptr];
    if (d == 0) step(2);
    else begin
      for (int unsigned i = 1; i < d; i++) tick();
      check({tag, "_hold"}, 32'(bus.buttons_o), 32'(m_btn));
      tick();
    end
    if (m_op[m_ptr] == 2'd0 || m_op[m_ptr] == 2'd1) begin
      m_btn = (m_op[m_ptr] == 2'd0) ? (m_btn | m_mask[m_ptr]) : (m_btn & ~m_mask[m_ptr]);
      m_strobes++;
      if (m_ptr == DP - 1) begin m_done = 1; m_busy = 0; end
      else m_ptr++;
    end else begin
      m_done = 1; m_busy = 0;
    end
    check_state(tag);
    bus.select_i = 8'($urandom); #1;
    check({tag, "_k"}, 32'(bus.input_k_o), 32'(model_k(m_btn, bus.select_i)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bus.step_tick_i = 0; bus.start_i = 0; bus.abort_i = 0; bus.wr_en_i = 0;
    bus.wr_addr_i = '0; bus.wr_delta_i = '0; bus.wr_op_i = '0; bus.wr_mask_i = '0;
    bus.map_wr_en_i = 0; bus.map_btn_i = '0; bus.map_sel_i = '0; bus.map_kbit_i = '0;
    bus.select_i = 8'hFF;
    for (int b = 0; b < NB; b++) begin m_sel[b] = 0; m_kbit[b] = 0; end
    m_btn = '0; m_ptr = 0; m_busy = 0; m_done = 0; m_strobes = 0;

    // Reset state
    reset_n = 1'b0;
    step(2);
    check_state("reset");
    check("reset_strobe", 32'(bus.event_strobe_o), 32'd0);
    check("reset_k", 32'(bus.input_k_o), 32'd0);
    reset_n = 1'b1;
    step(1);

    // Long-delay script, delays scaled down to keep the run short
    wr_map(0, 3, 2);
    wr_ev(0, 'h800, 0, 'h01);
    wr_ev(1, 'h080, 1, 'h01);
    wr_ev(2, 'h4E2, 2, 'h00);
    s0 = strobes;
    do_start();
    run_event("s1_press");
    bus.select_i = 8'h08; #1;
    check("s1_k_sel3", 32'(bus.input_k_o), 32'h4);
    bus.select_i = 8'hF7; #1;
    check("s1_k_nosel3", 32'(bus.input_k_o), 32'h0);
    run_event("s1_release");
    run_event("s1_finish");
    check("s1_done", 32'(bus.done_o), 32'd1);
    check("s1_nstrobe", 32'(strobes - s0), 32'd2);

    // Back-to-back zero-delay events
    wr_ev(0, 0, 0, 'h03);
    wr_ev(1, 0, 1, 'h01);
    wr_ev(2, 0, 2, 'h00);
    s0 = strobes;
    do_start();
    run_event("z_press");
    check("z_btn03", 32'(bus.buttons_o), 32'h03);
    run_event("z_release");
    check("z_btn02", 32'(bus.buttons_o), 32'h02);
    run_event("z_finish");
    check("z_nstrobe", 32'(strobes - s0), 32'd2);

    // Abort while done keeps done but clears buttons
    do_abort();
    check_state("abort_done");

    // Abort mid-wait, then replay from entry 0
    wr_ev(0, 1, 0, 'h05);
    wr_ev(1, 10, 1, 'h05);
    wr_ev(2, 0, 2, 'h00);
    do_start();
    run_event("ab_press");
    tick(); tick();
    check_state("ab_wait");
    do_abort();
    bus.select_i = 8'hFF; #1;
    check_state("ab_after");
    check("ab_k", 32'(bus.input_k_o), 32'd0);
    do_start();
    run_event("ab_replay");

    // Full table without FINISH wraps the pointer and ends playback
    for (int a = 0; a < DP; a++) wr_ev(a, 1, int'($urandom_range(1)), int'($urandom_range(255)));
    s0 = strobes;
    do_start();
    for (int i = 0; i < DP; i++) run_event("wrap");
    check("wrap_done", 32'(bus.done_o), 32'd1);
    check("wrap_nstrobe", 32'(strobes - s0), 32'(DP));

    // Shared select/K bit, then async reset mid-wait
    wr_map(1, 5, 1);
    wr_map(2, 5, 1);
    wr_ev(0, 0, 0, 'h02);
    wr_ev(1, 5, 1, 'h02);
    do_start();
    run_event("sh_press");
    bus.select_i = 8'h20; #1;
    check("sh_k_on", 32'(bus.input_k_o), 32'h2);
    bus.select_i = 8'h00; #1;
    check("sh_k_nosel", 32'(bus.input_k_o), 32'h0);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    m_btn = '0; m_busy = 0; m_done = 0;
    for (int b = 0; b < NB; b++) begin m_sel[b] = 0; m_kbit[b] = 0; end
    bus.select_i = 8'hFF; #1;
    check_state("rst_async");
    check("rst_strobe", 32'(bus.event_strobe_o), 32'd0);
    check("rst_k", 32'(bus.input_k_o), 32'd0);
    step(1);
    reset_n = 1'b1;
    step(1);
    do_start();
    run_event("rst_table_kept");
    do_abort();

    // start and abort together: abort wins
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    step(1);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    check_state("sa_now");
    step(3);
    check_state("sa_later");

    // Randomized scripts and maps
    for (int it = 0; it < 6; it++) begin
      for (int b = 0; b < NB; b++) wr_map(b, int'($urandom_range(SW - 1)), int'($urandom_range(3)));
      for (int a = 0; a < DP; a++) begin
        int r;
        r = int'($urandom_range(19));
        wr_ev(a, int'($urandom_range(4)), (r < 9) ? 0 : (r < 18) ? 1 : (r == 18) ? 2 : 3,
              int'($urandom_range(255)));
      end
      do_start();
      while (m_busy) run_event($sformatf("rnd%0d_e%0d", it, m_ptr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_script_player.md
Name: input_script_player

Overview:
- Synthesizable scripted button-press sequencer for Game & Watch CPU cores (sm510 family).
- Replays a loaded event list of press/release/finish actions, timed in retired CPU instructions.
- Drives the K input matrix from the CPU's select lines (shifter S or R outputs).
- Replaces hard-coded step-count stimulus. Usable in simulation and on hardware for attract or regression playback.

Parameters:
- NUM_BUTTONS, 8, number of logical buttons.
- DEPTH, 16, event table entries (power of 2).
- SEL_W, 8, width of select-line bus (8 for shifter S; 4 for R outputs).
- DELTA_W, 24, width of per-event step delay.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- step_tick  in  1  one-cycle pulse per retired CPU instruction
- start  in  1  pulse: begin playback from entry 0
- abort  in  1  pulse: stop playback, release all buttons
- wr_en  in  1  event table write strobe
- wr_addr  in  $clog2(DEPTH)  event table write address
- wr_delta  in  DELTA_W  steps to wait before applying the event
- wr_op  in  2  0=PRESS, 1=RELEASE, 2=FINISH, 3=reserved (treated as FINISH)
- wr_mask  in  NUM_BUTTONS  buttons affected
- map_wr_en  in  1  button map write strobe
- map_btn  in  $clog2(NUM_BUTTONS)  button index
- map_sel  in  $clog2(SEL_W)  select line the button sits on
- map_kbit  in  2  K bit driven when that select line is high
- select  in  SEL_W  CPU select lines
- input_k  out  4  K matrix input to CPU (combinational from registered state)
- buttons  out  NUM_BUTTONS  current held-button vector
- busy  out  1  playback active
- done  out  1  sticky: FINISH reached or table end
- event_strobe  out  1  one-cycle pulse when an event is applied

Behaviour:
- Reset values:
  - buttons=0, busy=0, done=0, event_strobe=0; FSM in IDLE.
  - Map entries: all sel=0, kbit=0.
  - Event table contents undefined.
- FSM states:
  - IDLE: start → LOAD, clear done and buttons, ptr=0.
  - LOAD: read entry[ptr] into the working register, cnt=delta. Next state WAIT, or APPLY if delta==0.
  - WAIT: each step_tick decrements cnt; when a tick makes cnt 0, go to APPLY on the next cycle.
  - APPLY:
    - PRESS: buttons |= mask.
    - RELEASE: buttons &= ~mask.
    - FINISH: go to DONE.
    - Assert event_strobe. ptr++; if ptr wraps to 0 (entry DEPTH-1 applied), go to DONE; else go to LOAD.
  - DONE: busy=0, done=1, buttons hold their last value. start restarts as from IDLE.
- Timing:
  - busy=1 in LOAD/WAIT/APPLY.
  - Latency from start to the first event with delta=N: N step_ticks, plus 2 cycles after the Nth tick (LOAD already done).
  - step_tick in LOAD/APPLY is ignored (not counted). Callers space ticks ≥3 cycles, which matches the CPU clk_en/stage rate.
- abort: any state → IDLE next cycle, buttons=0, done unchanged. abort outranks start in the same cycle.
- start while busy: restarts from entry 0 and clears buttons.
- wr_en during playback: permitted. Takes effect only for entries not yet loaded. Same-cycle write to the entry being loaded returns the old data.
- map_wr_en: updates the map on the clock edge; legal anytime.
- input_k:
  - bit j = OR over buttons b with buttons[b] && select[map_sel[b]] && map_kbit[b]==j.
  - Multiple buttons on the same sel/kbit OR together.
  - select=0 gives input_k=0.
- Counter: cnt is DELTA_W bits, with no wrap (maximum delay 2^DELTA_W-1 steps).
- Async reset mid-playback: immediate return to reset values; table contents preserved.

Decomposition:
- Package gw_input_pkg: op enum (OP_PRESS, OP_RELEASE, OP_FINISH), event struct {delta, op, mask}, FSM state enum.
- Sub-module input_k_matrix: combinational mapping of buttons, map, and select to input_k; reusable by the live-controller path.

Test Plan:
- Map btn0→sel3/kbit2. Table: {0x8000 PRESS 0x01}, {0x800 RELEASE 0x01}, {0x4E20 FINISH}. start, tick continuously:
  - buttons[0]=1 after tick 0x8000; input_k=4'h4 only while select[3]=1.
  - Release after a further 0x800 ticks.
  - done=1 after a further 0x4E20 ticks.
  - Exactly 2 event_strobes before done (FINISH gives none).
- delta=0 on entries 0 and 1 (PRESS 0x03, RELEASE 0x01): buttons=0x03, then 0x02, on consecutive APPLY passes with no ticks; 2 strobes.
- abort asserted mid-WAIT with buttons=0x05 → next cycle busy=0, buttons=0, input_k=0; a following start replays from entry 0.
- Table of DEPTH entries with no FINISH, all delta=1: done after DEPTH ticks; ptr wraps; DEPTH strobes.
- Two buttons mapped to the same sel/kbit, one pressed → bit set; select line low → input_k=0; reset_n low mid-WAIT → all outputs at reset values asynchronously.
- start and abort in the same cycle → FSM stays IDLE, busy=0.
